// File: rtl/ex_mem_pkg.sv
// Shared pipeline constants and the control code used by the EX->MEM register.
package ex_mem_pkg;

    localparam logic RstEnable    = 1'b1;
    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;
    localparam logic WriteDisable = 1'b0;
    localparam int   RegBus       = 32;
    localparam int   DoubleRegBus = 64;
    localparam int   RegAddrBus   = 5;
    localparam int   AluOpBus     = 8;
    localparam logic [31:0] ZeroWord   = 32'h0;
    localparam logic [7:0]  EXE_NOP_OP = 8'h00;

    // Per-edge action for a pipe_stage_reg; reset is handled separately.
    typedef enum logic [1:0] {
        STG_ADV    = 2'd0,
        STG_BUBBLE = 2'd1,
        STG_HOLD   = 2'd2,
        STG_CLEAR  = 2'd3
    } stage_ctl_e;

endpackage

// File: rtl/ex_mem_stage_reg.sv
// Generic W-bit pipeline register: reset/clear to zero, else load bubble or
// advance value, else hold.
module pipe_stage_reg
    import ex_mem_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  stage_ctl_e   ctl,
    input  logic [W-1:0] adv_d,
    input  logic [W-1:0] bub_d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            q <= '0;
        end else begin
            unique case (ctl)
                STG_CLEAR:  q <= '0;
                STG_BUBBLE: q <= bub_d;
                STG_ADV:    q <= adv_d;
                default:    q <= q;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem.sv
// EX->MEM pipeline register with stall/bubble/flush control; also carries the
// two-cycle MAC partial state back to EX across the stall bubble.
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int REG_W   = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 8,
    parameter int STALL_W = 6,
    parameter int MY_STG  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic [ADDR_W-1:0]    ex_wd,
    input  logic                 ex_wreg,
    input  logic [REG_W-1:0]     ex_wdata,
    input  logic                 ex_whilo,
    input  logic [REG_W-1:0]     ex_hi,
    input  logic [REG_W-1:0]     ex_lo,
    input  logic [ALUOP_W-1:0]   ex_aluop,
    input  logic [REG_W-1:0]     ex_mem_addr,
    input  logic [REG_W-1:0]     ex_reg2,
    input  logic [2*REG_W-1:0]   hilo_i,
    input  logic [1:0]           cnt_i,
    output logic [ADDR_W-1:0]    mem_wd,
    output logic                 mem_wreg,
    output logic [REG_W-1:0]     mem_wdata,
    output logic                 mem_whilo,
    output logic [REG_W-1:0]     mem_hi,
    output logic [REG_W-1:0]     mem_lo,
    output logic [ALUOP_W-1:0]   mem_aluop,
    output logic [REG_W-1:0]     mem_mem_addr,
    output logic [REG_W-1:0]     mem_reg2,
    output logic [2*REG_W-1:0]   hilo_o,
    output logic [1:0]           cnt_o
);

    localparam int MEM_W = ADDR_W + 2 + 5*REG_W + ALUOP_W;
    localparam int MAC_W = 2*REG_W + 2;

    localparam logic [MEM_W-1:0] MEM_BUBBLE = {
        {ADDR_W{1'b0}}, WriteDisable, {REG_W{1'b0}}, WriteDisable,
        {2*REG_W{1'b0}}, ALUOP_W'(EXE_NOP_OP), {2*REG_W{1'b0}}
    };
    localparam logic [MAC_W-1:0] MAC_IDLE = '0;

    stage_ctl_e       ctl;
    logic             my_stall, next_stall;
    logic [MEM_W-1:0] mem_d, mem_q;
    logic [MAC_W-1:0] mac_d, mac_q;

    assign my_stall   = (stall[MY_STG]   == Stop);
    assign next_stall = (stall[MY_STG+1] == Stop);

    // Downstream stalled while EX runs is not produced by ctrl; it falls into hold.
    always_comb begin
        ctl = STG_HOLD;
        if (flush)
            ctl = STG_CLEAR;
        else if (my_stall && !next_stall)
            ctl = STG_BUBBLE;
        else if (!my_stall && !next_stall)
            ctl = STG_ADV;
    end

    assign mem_d = {ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
                    ex_aluop, ex_mem_addr, ex_reg2};
    assign {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
            mem_aluop, mem_mem_addr, mem_reg2} = mem_q;

    pipe_stage_reg #(.W(MEM_W)) u_mem_reg (
        .clk   (clk),
        .rst   (rst),
        .ctl   (ctl),
        .adv_d (mem_d),
        .bub_d (MEM_BUBBLE),
        .q     (mem_q)
    );

    // MAC state survives only through the bubble; an advance means it finished.
    assign mac_d           = {hilo_i, cnt_i};
    assign {hilo_o, cnt_o} = mac_q;

    pipe_stage_reg #(.W(MAC_W)) u_mac_reg (
        .clk   (clk),
        .rst   (rst),
        .ctl   (ctl),
        .adv_d (MAC_IDLE),
        .bub_d (mac_d),
        .q     (mac_q)
    );

endmodule

// File: tb/tb_ex_mem.sv
// Directed plus randomized checks of ex_mem against a per-edge behavioural model.
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi, ex_lo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr, ex_reg2;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi, mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr, mem_reg2;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi, lo;
        logic [7:0]  aluop;
        logic [31:0] addr, reg2;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } model_t;

    model_t m;
    int tests = 0;
    int failed = 0;

    ex_mem dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop),
        .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".wd"},    64'(mem_wd),       64'(m.wd));
        chk({tag, ".wreg"},  64'(mem_wreg),     64'(m.wreg));
        chk({tag, ".wdata"}, 64'(mem_wdata),    64'(m.wdata));
        chk({tag, ".whilo"}, 64'(mem_whilo),    64'(m.whilo));
        chk({tag, ".hi"},    64'(mem_hi),       64'(m.hi));
        chk({tag, ".lo"},    64'(mem_lo),       64'(m.lo));
        chk({tag, ".aluop"}, 64'(mem_aluop),    64'(m.aluop));
        chk({tag, ".addr"},  64'(mem_mem_addr), 64'(m.addr));
        chk({tag, ".reg2"},  64'(mem_reg2),     64'(m.reg2));
        chk({tag, ".hilo"},  hilo_o,            m.hilo);
        chk({tag, ".cnt"},   64'(cnt_o),        64'(m.cnt));
    endtask

    // Model the edge from the current inputs, clock it, then compare.
    task automatic step(input string tag);
        model_t zero;
        zero = '{default: '0};
        assert (!(stall[4] && !stall[3])) else $error("FAIL illegal_stall observed=%b", stall);
        if (rst || flush) begin
            m = zero;
        end else if (stall[3] && !stall[4]) begin
            m = zero;
            m.hilo = hilo_i;
            m.cnt  = cnt_i;
        end else if (!stall[3]) begin
            m = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, whilo: ex_whilo,
                  hi: ex_hi, lo: ex_lo, aluop: ex_aluop, addr: ex_mem_addr,
                  reg2: ex_reg2, hilo: 64'h0, cnt: 2'd0};
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic rand_ex();
        ex_wd       = 5'($urandom);
        ex_wreg     = 1'($urandom);
        ex_wdata    = $urandom;
        ex_whilo    = 1'($urandom);
        ex_hi       = $urandom;
        ex_lo       = $urandom;
        ex_aluop    = 8'($urandom);
        ex_mem_addr = $urandom;
        ex_reg2     = $urandom;
        hilo_i      = {$urandom, $urandom};
        cnt_i       = 2'($urandom_range(0, 3));
    endtask

    initial begin
        m = '{default: '0};
        rst = 1'b1; flush = 1'b0; stall = 6'b0;
        rand_ex();
        // T1 reset with nonzero inputs
        ex_wdata = 32'hDEADBEEF; ex_wreg = 1'b1;
        step("t1_rst0");
        step("t1_rst1");
        chk("t1_wdata_zero", 64'(mem_wdata), 64'h0);

        // T2 advance
        rst = 1'b0; rand_ex();
        ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
        step("t2_adv");
        chk("t2_wd", 64'(mem_wd), 64'd3);
        chk("t2_wdata", 64'(mem_wdata), 64'h1234_5678);

        // T3 bubble latches MAC state, release clears it
        rand_ex(); stall = 6'b001111; hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
        step("t3_bubble");
        chk("t3_hilo", hilo_o, 64'h1_0000_0002);
        chk("t3_cnt", 64'(cnt_o), 64'd1);
        rand_ex(); stall = 6'b0;
        step("t3_release");
        chk("t3_cnt_clr", 64'(cnt_o), 64'd0);

        // T4 hold
        rand_ex(); ex_wdata = 32'hA5A5A5A5;
        step("t4_load");
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            rand_ex();
            step("t4_hold");
        end
        chk("t4_wdata_held", 64'(mem_wdata), 64'hA5A5A5A5);

        // T5 flush beats bubble
        stall = 6'b0; rand_ex(); step("t5_pre");
        rand_ex(); flush = 1'b1; stall = 6'b001111; ex_wreg = 1'b1; cnt_i = 2'd1;
        step("t5_flush");
        flush = 1'b0;

        // T6 reset mid-MAC, then normal transfer
        rand_ex(); stall = 6'b001111; cnt_i = 2'd1;
        step("t6_mac");
        rand_ex(); rst = 1'b1;
        step("t6_rst");
        chk("t6_cnt_zero", 64'(cnt_o), 64'd0);
        rst = 1'b0; stall = 6'b0; rand_ex();
        step("t6_after");

        // Randomized mix of advance/bubble/hold/flush/reset
        for (int i = 0; i < 300; i++) begin
            rand_ex();
            case ($urandom_range(0, 5))
                0, 1: stall = 6'b000000;
                2:    stall = 6'b000111;
                3:    stall = 6'b001111;
                4:    stall = 6'b011111;
                default: stall = 6'b111111;
            endcase
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 31) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
